// File: rtl/eth_payload_writer_if.sv
// Payload AXI-Stream channel between the payload writer and the Ethernet TX core.
// A beat transfers on a rising clk edge where tvalid && tready; the master holds tdata/tlast stable and tvalid high until that transfer.
interface eth_payload_writer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_payload_writer.sv
// Streams a frame payload from a byte buffer (1-cycle read latency) onto AXI-Stream via a 2-entry prefetch FIFO.
// Optional ETH_PAYLOAD_MIN_PAD_EN zero-pads the payload to a 46-byte minimum.
module eth_payload_writer #(
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] arg_0_raddr_o,
    output logic                  arg_0_ren_o,
    input  logic [7:0]            arg_0_rdata_i,
    eth_payload_writer_if.master  arg_3_s_eth_payload_axis,
    output logic [1:0]            state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   total_q, total_d, total_new;
    logic [LEN_WIDTH-1:0]   rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [ADDR_WIDTH-1:0]  raddr_q, rd_addr;
    logic                   inflight_q;
    logic [7:0]             mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;
    logic [2:0]             occ;
    logic                   accept, gen, ren, is_read, pop, push, tvalid, tlast;
    logic [7:0]             push_data;

`ifdef ETH_PAYLOAD_MIN_PAD_EN
    localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(46);
    logic [LEN_WIDTH-1:0] len_q;
    logic                 pad_q;

    assign total_new = (len_i < MIN_LEN) ? MIN_LEN : len_i;
    assign is_read   = (rd_cnt_q < len_q);
    // Pad bytes travel the same one-cycle slot as a read so only one push happens per cycle.
    assign push_data = pad_q ? 8'h00 : arg_0_rdata_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            pad_q <= 1'b0;
        end else begin
            if (accept) len_q <= len_i;
            pad_q <= accept ? 1'b0 : (gen && !is_read);
        end
    end
`else
    assign total_new = len_i;
    assign is_read   = 1'b1;
    assign push_data = arg_0_rdata_i;
`endif

    generate
        if (ADDR_WIDTH > LEN_WIDTH) begin : g_zext
            assign rd_addr = {{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, rd_cnt_q};
        end else begin : g_trunc
            assign rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign accept = start_i && (state_q != STREAM);
    assign tvalid = (count_q != 2'd0);
    assign pop    = tvalid && arg_3_s_eth_payload_axis.tready;
    assign tlast  = tvalid && (tx_cnt_q == total_q - ONE);
    assign push   = inflight_q;
    assign occ    = {1'b0, count_q} + {2'b00, inflight_q};
    // A popping beat frees a slot this cycle, which keeps the pipe at one beat per cycle.
    assign gen    = (state_q == STREAM) && (rd_cnt_q < total_q) && ((occ < 3'd2) || pop);
    assign ren    = gen && is_read;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        rd_cnt_d = rd_cnt_q;
        tx_cnt_d = tx_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    total_d  = total_new;
                    rd_cnt_d = '0;
                    tx_cnt_d = '0;
                    state_d  = (total_new == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (gen) rd_cnt_d = rd_cnt_q + ONE;
                if (pop) tx_cnt_d = tx_cnt_q + ONE;
                if (pop && tlast) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            total_q    <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            if (ren) raddr_q <= rd_addr;
            inflight_q <= accept ? 1'b0 : gen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign busy_o        = (state_q == STREAM);
    assign valid_o       = (state_q == DONE);
    assign arg_0_ren_o   = ren;
    assign arg_0_raddr_o = ren ? rd_addr : raddr_q;
    assign state_o       = state_q;

    assign arg_3_s_eth_payload_axis.tdata  = tvalid ? mem_q[rd_ptr_q] : 8'h00;
    assign arg_3_s_eth_payload_axis.tvalid = tvalid;
    assign arg_3_s_eth_payload_axis.tlast  = tlast;
    assign arg_3_s_eth_payload_axis.tuser  = 1'b0;
endmodule

// File: tb/tb_eth_payload_writer.sv
// Directed bench for eth_payload_writer: buffer model, stream sink, immediate-assertion checks.
module tb_eth_payload_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy, valid, ren;
    logic [15:0] raddr;
    logic [7:0]  rdata = 8'h00;
    logic [1:0]  state;
    int          n_vec = 0;
    int          n_err = 0;

    eth_payload_writer_if axis ();

    eth_payload_writer #(.LEN_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .len_i(len),
        .busy_o(busy), .valid_o(valid),
        .arg_0_raddr_o(raddr), .arg_0_ren_o(ren), .arg_0_rdata_i(rdata),
        .arg_3_s_eth_payload_axis(axis), .state_o(state)
    );

    always #5 clk = ~clk;

    // Buffer: byte i holds (i+1)*0x11; non-read cycles return noise.
    function automatic logic [7:0] bexp(input int i);
        return 8'((i + 1) * 17);
    endfunction

    always @(posedge clk) rdata <= ren ? bexp(int'(raddr[7:0])) : 8'($urandom_range(0, 255));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start in the current cycle; returns settled in cycle S+1.
    task automatic start_frame(input int n);
        start = 1'b1;
        len   = 16'(n);
        tick();
        start = 1'b0;
        len   = '0;
        #1;
    endtask

    // Runs a frame from S+1 until valid; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1.
    task automatic drain(input int n_data, input int n_total, input int mode, output int beats, output int rens);
        logic       done = 1'b0;
        logic       stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] exp_b;
        beats = 0;
        rens  = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) tick();
            axis.tready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            #1;
            chk("occupancy", 32'((rens - beats) <= 2), 32'd1);
            if (stalled) begin
                chk("stall_tvalid", 32'(axis.tvalid), 32'd1);
                chk("stall_tdata", 32'(axis.tdata), 32'(held));
            end
            if (axis.tvalid && axis.tready) begin
                exp_b = (beats < n_data) ? bexp(beats) : 8'h00;
                chk("beat_data", 32'(axis.tdata), 32'(exp_b));
                chk("beat_last", 32'(axis.tlast), 32'(beats == n_total - 1));
                beats++;
            end
            stalled = axis.tvalid && !axis.tready;
            held    = axis.tdata;
            if (ren) rens++;
            if (valid) done = 1'b1;
        end
        chk("frame_done", 32'(done), 32'd1);
        chk("beat_count", 32'(beats), 32'(n_total));
        axis.tready = 1'b1;
    endtask

    initial begin
        int beats, rens, rises;
        logic prev_valid;
        axis.tready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tlast", 32'(axis.tlast), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        chk("rst_tuser", 32'(axis.tuser), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

`ifdef ETH_PAYLOAD_MIN_PAD_EN
        start_frame(0);
        chk("pad0_busy", 32'(busy), 32'd1);
        drain(0, 46, 0, beats, rens);
        chk("pad0_rens", 32'(rens), 32'd0);
        tick();
        start_frame(10);
        drain(10, 46, 0, beats, rens);
        chk("pad10_rens", 32'(rens), 32'd10);
`else
        // Empty frame goes straight to DONE.
        start_frame(0);
        chk("len0_valid", 32'(valid), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_ren", 32'(ren), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_tvalid", 32'(axis.tvalid), 32'd0);
            tick();
        end

        // len=4, full rate, started from DONE.
        start_frame(4);
        chk("f4_valid_drop", 32'(valid), 32'd0);
        chk("f4_busy", 32'(busy), 32'd1);
        chk("f4_ren0", 32'(ren), 32'd1);
        chk("f4_raddr0", 32'(raddr), 32'd0);
        chk("f4_tvalid_s1", 32'(axis.tvalid), 32'd0);
        tick();
        chk("f4_tvalid_s2", 32'(axis.tvalid), 32'd0);
        chk("f4_raddr1", 32'(raddr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f4_tvalid", 32'(axis.tvalid), 32'd1);
            chk("f4_tdata", 32'(axis.tdata), 32'(bexp(i)));
            chk("f4_tlast", 32'(axis.tlast), 32'(i == 3));
        end
        tick();
        chk("f4_valid", 32'(valid), 32'd1);
        chk("f4_busy_end", 32'(busy), 32'd0);
        chk("f4_tvalid_end", 32'(axis.tvalid), 32'd0);
        chk("f4_ren_end", 32'(ren), 32'd0);
        chk("f4_raddr_hold", 32'(raddr), 32'd3);

        // len=6 under toggled backpressure.
        tick();
        start_frame(6);
        drain(6, 6, 1, beats, rens);
        chk("f6_rens", 32'(rens), 32'd6);

        // start during STREAM is ignored.
        tick();
        start_frame(5);
        beats = 0;
        rises = 0;
        prev_valid = valid;
        for (int c = 0; c < 40; c++) begin
            tick();
            start = (c == 1);
            len   = (c == 1) ? 16'd3 : 16'd0;
            #1;
            if (axis.tvalid && axis.tready) begin
                chk("ign_data", 32'(axis.tdata), 32'(bexp(beats)));
                beats++;
            end
            if (valid && !prev_valid) rises++;
            prev_valid = valid;
        end
        chk("ign_beats", 32'(beats), 32'd5);
        chk("ign_valid_rises", 32'(rises), 32'd1);
        chk("ign_valid", 32'(valid), 32'd1);

        // Reset mid-frame after 3 beats of len=8, with a read in flight.
        start_frame(8);
        tick(); tick(); tick(); tick();
        chk("mr_beat2", 32'(axis.tdata), 32'(bexp(2)));
        tick();
        rst = 1'b1;
        axis.tready = 1'b0;
        tick();
        rst = 1'b0;
        axis.tready = 1'b1;
        #1;
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_ren", 32'(ren), 32'd0);
        chk("mr_raddr", 32'(raddr), 32'd0);
        chk("mr_tvalid", 32'(axis.tvalid), 32'd0);
        chk("mr_tlast", 32'(axis.tlast), 32'd0);
        chk("mr_tdata", 32'(axis.tdata), 32'd0);
        tick();
        chk("mr_tvalid_idle", 32'(axis.tvalid), 32'd0);
        start_frame(2);
        chk("r2_raddr0", 32'(raddr), 32'd0);
        tick(); tick();
        chk("r2_tdata0", 32'(axis.tdata), 32'(bexp(0)));
        chk("r2_tlast0", 32'(axis.tlast), 32'd0);
        tick();
        chk("r2_tdata1", 32'(axis.tdata), 32'(bexp(1)));
        chk("r2_tlast1", 32'(axis.tlast), 32'd1);
        tick();
        chk("r2_valid", 32'(valid), 32'd1);
        chk("r2_tvalid_end", 32'(axis.tvalid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
